// File: rtl/miriscv_pkg.sv
// miriscv_pkg: core-wide constants and shared types.
//   XLEN          - architectural register / pc width
//   fetch_entry_t - one fetch response as held in the instruction queue
package miriscv_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/miriscv_instr_queue.sv
// miriscv_instr_queue: decoupling FIFO between fetch and decode.
//
// Each valid fetch response is captured as one {pc, pc_next, instr} entry and
// presented to decode in order through a valid/ready handshake. The head is
// read straight out of storage (first-word fall-through, no bypass), so a push
// into an empty queue becomes visible to decode one cycle later.
//
// Ports:
//   clk_i                  rising-edge clock
//   arstn_i                asynchronous active-low reset
//   fetch_rvalid_i         fetch response valid (push request)
//   fetched_pc_addr_i      pc of the fetched instruction
//   fetched_pc_next_addr_i pc + 4 of the fetched instruction
//   instr_i                fetched instruction word
//   cu_kill_f_i            flush everything (branch/jump redirect)
//   decode_ready_i         decode accepts the head entry
//   decode_valid_o         head entry valid
//   decode_pc_o            head pc
//   decode_pc_next_o       head pc + 4
//   decode_instr_o         head instruction
//   full_o                 count == DEPTH
//   almost_full_o          count >= DEPTH-1
//   count_o                number of occupied entries
//   overflow_o             sticky: push attempted while full without a pop
module miriscv_instr_queue
  import miriscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     arstn_i,
  input  logic                     fetch_rvalid_i,
  input  logic [XLEN-1:0]          fetched_pc_addr_i,
  input  logic [XLEN-1:0]          fetched_pc_next_addr_i,
  input  logic [31:0]              instr_i,
  input  logic                     cu_kill_f_i,
  input  logic                     decode_ready_i,
  output logic                     decode_valid_o,
  output logic [XLEN-1:0]          decode_pc_o,
  output logic [XLEN-1:0]          decode_pc_next_o,
  output logic [31:0]              decode_instr_o,
  output logic                     full_o,
  output logic                     almost_full_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t             mem [DEPTH];
  fetch_entry_t             wr_entry;
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [CNT_W-1:0]         count;
  logic                     overflow;
  logic                     full;
  logic                     push;
  logic                     pop;

  // Flags are decoded from the registered count only.
  assign full          = (count == CNT_W'(DEPTH));
  assign full_o        = full;
  assign almost_full_o = (count >= CNT_W'(DEPTH - 1));
  assign count_o       = count;
  assign overflow_o    = overflow;

  // A kill hides the head in the same cycle so decode never consumes a
  // squashed instruction.
  assign decode_valid_o = (count != '0) & ~cu_kill_f_i;

  assign pop  = decode_valid_o & decode_ready_i;
  // When full, a same-cycle pop frees the slot that this push refills.
  assign push = fetch_rvalid_i & ~cu_kill_f_i & (~full | pop);

  assign wr_entry.pc      = fetched_pc_addr_i;
  assign wr_entry.pc_next = fetched_pc_next_addr_i;
  assign wr_entry.instr   = instr_i;

  assign decode_pc_o      = mem[rd_ptr].pc;
  assign decode_pc_next_o = mem[rd_ptr].pc_next;
  assign decode_instr_o   = mem[rd_ptr].instr;

  // Storage: written only on an accepted push.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointers, occupancy and the sticky overflow flag. Kill wins over
  // everything else and returns the queue to its post-reset state.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (cu_kill_f_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A response arriving with nowhere to go is lost; flag it until the
      // next redirect or reset.
      if (fetch_rvalid_i && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_miriscv_instr_queue.sv
module tb_miriscv_instr_queue;
  import miriscv_pkg::*;

  localparam int DEPTH = 4;

  logic              clk;
  logic              arstn;
  logic              rvalid;
  logic [XLEN-1:0]   pc_in;
  logic [XLEN-1:0]   pc_next_in;
  logic [31:0]       instr_in;
  logic              kill;
  logic              rdy;
  logic              d_valid;
  logic [XLEN-1:0]   d_pc;
  logic [XLEN-1:0]   d_pc_next;
  logic [31:0]       d_instr;
  logic              full;
  logic              afull;
  logic [$clog2(DEPTH):0] count;
  logic              ovf;

  miriscv_instr_queue #(.DEPTH(DEPTH)) dut (
    .clk_i                  (clk),
    .arstn_i                (arstn),
    .fetch_rvalid_i         (rvalid),
    .fetched_pc_addr_i      (pc_in),
    .fetched_pc_next_addr_i (pc_next_in),
    .instr_i                (instr_in),
    .cu_kill_f_i            (kill),
    .decode_ready_i         (rdy),
    .decode_valid_o         (d_valid),
    .decode_pc_o            (d_pc),
    .decode_pc_next_o       (d_pc_next),
    .decode_instr_o         (d_instr),
    .full_o                 (full),
    .almost_full_o          (afull),
    .count_o                (count),
    .overflow_o             (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: an ordered list of entries plus a sticky overflow flag.
  fetch_entry_t model_q[$];
  bit           model_ovf;

  logic [XLEN-1:0] popped[$];
  logic            last_valid;

  function automatic logic [31:0] instr_of(input logic [XLEN-1:0] pc);
    return pc ^ 32'hA5A5_0013;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs just after the falling edge, compare all
  // outputs against the model, then advance the model across the rising edge.
  task automatic step(input bit rv, input logic [XLEN-1:0] pc, input bit k, input bit r);
    bit exp_valid;
    bit m_pop;
    bit m_push;
    fetch_entry_t e;
    rvalid     = rv;
    pc_in      = pc;
    pc_next_in = pc + 32'd4;
    instr_in   = instr_of(pc);
    kill       = k;
    rdy        = r;
    #1;
    exp_valid = (model_q.size() != 0) && !k;
    chk("decode_valid", d_valid, exp_valid);
    chk("count", count, model_q.size());
    chk("full", full, model_q.size() == DEPTH);
    chk("almost_full", afull, model_q.size() >= DEPTH - 1);
    chk("overflow", ovf, model_ovf);
    if (exp_valid) begin
      chk("head_pc", d_pc, model_q[0].pc);
      chk("head_pc_next", d_pc_next, model_q[0].pc_next);
      chk("head_instr", d_instr, model_q[0].instr);
    end
    last_valid = d_valid;
    if (d_valid && r) popped.push_back(d_pc);
    @(posedge clk);
    if (k) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      m_pop  = exp_valid && r;
      m_push = rv && ((model_q.size() < DEPTH) || m_pop);
      if (rv && model_q.size() == DEPTH && !m_pop) model_ovf = 1'b1;
      if (m_pop) void'(model_q.pop_front());
      if (m_push) begin
        e.pc      = pc;
        e.pc_next = pc + 32'd4;
        e.instr   = instr_of(pc);
        model_q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, d_valid, 0);
    chk({tag, "_pc"}, d_pc, 0);
    chk({tag, "_pc_next"}, d_pc_next, 0);
    chk({tag, "_instr"}, d_instr, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_afull"}, afull, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    logic [XLEN-1:0] rpc;
    arstn = 1'b0; rvalid = 1'b0; pc_in = '0; pc_next_in = '0;
    instr_in = '0; kill = 1'b0; rdy = 1'b0;
    model_ovf = 1'b0;
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    arstn = 1'b1;

    // Three pushes with decode stalled.
    step(1, 32'h100, 0, 0);
    chk("first_head_valid", d_valid, 1);
    chk("first_head_pc", d_pc, 32'h100);
    step(1, 32'h104, 0, 0);
    step(1, 32'h108, 0, 0);
    chk("three_count", count, 3);
    chk("three_afull", afull, 1);
    chk("three_full", full, 0);

    // Fill, then overflow with 0x200.
    step(1, 32'h10C, 0, 0);
    chk("fill_full", full, 1);
    step(1, 32'h200, 0, 0);
    chk("ovf_set", ovf, 1);
    chk("ovf_count", count, 4);
    popped.delete();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    chk("drain_n", popped.size(), 4);
    for (int i = 0; i < 4 && i < popped.size(); i++)
      chk("drain_order", popped[i], 32'h100 + 32'(4 * i));
    chk("ovf_sticky", ovf, 1);

    // Full queue with simultaneous push and pop.
    for (int i = 0; i < 4; i++) step(1, 32'h100 + 32'(4 * i), 0, 0);
    step(1, 32'h110, 0, 1);
    chk("pp_count", count, 4);
    chk("pp_head", d_pc, 32'h104);
    popped.delete();
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    chk("pp_n", popped.size(), 4);
    if (popped.size() == 4) chk("pp_last", popped[3], 32'h110);

    // Sustained streaming across pointer wrap.
    popped.delete();
    for (int i = 0; i < 20; i++) step(1, 32'h500 + 32'(4 * i), 0, 1);
    step(0, 0, 0, 1);
    chk("stream_n", popped.size(), 20);
    for (int i = 0; i < 20 && i < popped.size(); i++)
      chk("stream_order", popped[i], 32'h500 + 32'(4 * i));

    // Kill with two entries and concurrent push/pop requests.
    step(1, 32'h600, 0, 0);
    step(1, 32'h604, 0, 0);
    step(1, 32'h608, 1, 1);
    chk("kill_valid", last_valid, 0);
    chk("kill_count", count, 0);
    chk("kill_ovf", ovf, 0);
    step(1, 32'h400, 0, 0);
    chk("kill_next_head", d_pc, 32'h400);
    step(0, 0, 0, 1);

    // Asynchronous reset between clock edges with three entries.
    step(1, 32'h700, 0, 0);
    step(1, 32'h704, 0, 0);
    step(1, 32'h708, 0, 0);
    #2 arstn = 1'b0;
    rvalid = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_q.delete();
    model_ovf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    arstn = 1'b1;
    step(0, 0, 0, 1);
    chk("post_rst_count", count, 0);
    step(1, 32'h800, 0, 0);
    chk("post_rst_head", d_pc, 32'h800);

    // Randomized traffic against the model.
    rpc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, rpc, $urandom_range(0, 29) == 0,
           $urandom_range(0, 2) != 0);
      rpc = rpc + 32'd4;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
